mem_responder: RTL and testbench

- Memory-side responder for the multicycle processor's load/store and LM/SM traffic: the other end of the controller's memread/memwrite requests.
- Accepts one request per transaction: single or burst of up to 8 words, incrementing address. Inserts a configurable wait latency, then moves one word per cycle.
- Signals beat-level progress and a completion pulse so the controller can stall instead of assuming fixed memory timing.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_array.sv | 36 +++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Types and constants shared by the memory responder and the controller-side
// stall logic.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      XFER,
      DONE
   } mem_state_e;

   localparam int MEM_DATA_W    = 16;
   localparam int MEM_LEN_W     = 3;
   localparam int MEM_MAX_BURST = 8;
   localparam int MEM_LATENCY   = 2;
   localparam int MEM_WAIT_W    = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one access per cycle, registered read port.
// Contents are never reset; only the read register is.
module mem_array #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register holds its last value between read accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts single or burst requests, waits LATENCY
// cycles, then moves one word per cycle and pulses done (with err if out of range).
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W  = MEM_DATA_W,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = MEM_LATENCY
) (
   input  logic                 clk,
   input  logic                 proc_rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [15:0]          req_addr,
   input  logic [MEM_LEN_W-1:0] req_len,
   input  logic [DATA_W-1:0]    wdata,
   output logic                 wack,
   output logic [DATA_W-1:0]    rdata,
   output logic                 rvalid,
   output logic                 done,
   output logic                 err
);

   mem_state_e            state_q, state_d;
   logic [MEM_WAIT_W-1:0] wait_q, wait_d;
   logic [MEM_LEN_W-1:0]  beat_q, beat_d;
   logic [MEM_LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  we_q, we_d;
   logic                  err_q, err_d;
   logic                  rvalid_q, rvalid_d;
   logic                  mem_en;
   logic                  addr_oor;

   assign addr_oor = (req_addr >> ADDR_W) != 16'd0;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      beat_d    = beat_q;
      len_d     = len_q;
      addr_d    = addr_q;
      we_d      = we_q;
      err_d     = err_q;
      req_ready = 1'b0;
      wack      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d   = req_we;
               addr_d = req_addr[ADDR_W-1:0];
               len_d  = req_len;
               beat_d = '0;
               if (addr_oor) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (LATENCY == 1) begin
                  state_d = XFER;
               end else begin
                  wait_d  = MEM_WAIT_W'(LATENCY - 2);
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_q == '0) begin
               state_d = XFER;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         XFER: begin
            // Address wraps naturally at ADDR_W bits, so bursts roll over to word 0.
            mem_en = 1'b1;
            wack   = we_q;
            addr_d = addr_q + 1'b1;
            beat_d = beat_q + 1'b1;
            if (beat_q == len_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            err     = err_q;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rvalid_d = (state_q == XFER) && !we_q;

   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         beat_q   <= '0;
         len_q    <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         beat_q   <= beat_d;
         len_q    <= len_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rvalid = rvalid_q;

   mem_array #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_mem (
      .clk    (clk),
      .rst_n  (proc_rst),
      .en_i   (mem_en),
      .we_i   (we_q),
      .addr_i (addr_q),
      .wdata_i(wdata),
      .rdata_o(rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// write/read pairs checked against a word-array reference with cycle-level timing rules.
module tb_mem_responder;

   localparam int LAT = 2;

   logic        clk       = 1'b0;
   logic        proc_rst  = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [15:0] req_addr  = '0;
   logic [2:0]  req_len   = '0;
   logic [15:0] wdata     = '0;
   logic        req_ready, wack, rvalid, done, err;
   logic [15:0] rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference memory: value plus "has been written" flag per word.
   logic [15:0] ref_mem [256];
   bit          known   [256];
   logic [15:0] wd      [8];

   // Observations of the last transaction (cycle numbers, -1 = never seen).
   int          t_acc, done_cyc, ready_cyc, n_done;
   int          n_wack, first_wack, last_wack;
   int          n_rv, first_rv, last_rv;
   logic        err_obs;
   logic [15:0] rd_q [$];
   logic [4:0]  rst_snap;
   logic [15:0] rst_rdata;
   logic        nx_we;
   logic [15:0] nx_addr;
   logic [2:0]  nx_len;

   mem_responder #(
      .DATA_W (16),
      .ADDR_W (8),
      .LATENCY(LAT)
   ) dut (
      .clk      (clk),
      .proc_rst (proc_rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_len  (req_len),
      .wdata    (wdata),
      .wack     (wack),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Master: present a request, feed wdata on wack, record everything until
   // req_ready returns. Entered and left between a falling and a rising edge.
   task automatic run_txn(input logic we, input logic [15:0] addr, input logic [2:0] len,
                          input bit hold_next, input int rst_at);
      int k;
      k = 0;
      t_acc = -1; done_cyc = -1; ready_cyc = -1; n_done = 0; err_obs = 1'b0;
      n_wack = 0; first_wack = -1; last_wack = -1;
      n_rv = 0; first_rv = -1; last_rv = -1;
      rd_q.delete();
      req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; wdata = wd[0];
      for (int n = 0; n < 80; n++) begin
         if (t_acc >= 0 && rst_at >= 0 && cyc == t_acc + rst_at) begin
            proc_rst = 1'b0;
            #1;
            rst_snap  = {req_ready, wack, rvalid, done, err};
            rst_rdata = rdata;
            break;
         end
         if (t_acc < 0) begin
            if (req_ready) t_acc = cyc;
         end else begin
            if (wack) begin
               if (first_wack < 0) first_wack = cyc;
               last_wack = cyc; n_wack++; k++;
            end
            if (rvalid) begin
               if (first_rv < 0) first_rv = cyc;
               last_rv = cyc; n_rv++; rd_q.push_back(rdata);
            end
            if (done) begin
               n_done++; done_cyc = cyc; err_obs = err;
            end
            if (req_ready) begin
               ready_cyc = cyc;
               break;
            end
         end
         @(posedge clk);
         #1;
         if (t_acc >= 0) begin
            if (hold_next) begin
               req_valid = 1'b1; req_we = nx_we; req_addr = nx_addr; req_len = nx_len;
            end else begin
               req_valid = 1'b0; req_we = 1'($urandom);
               req_addr = 16'($urandom); req_len = 3'($urandom);
            end
         end
         wdata = (k < 8) ? wd[k] : 16'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic model_apply(input logic we, input logic [15:0] addr, input logic [2:0] len);
      logic [7:0] a;
      if (we && addr < 16'h0100) begin
         for (int i = 0; i <= int'(len); i++) begin
            a = addr[7:0] + 8'(i);
            ref_mem[a] = wd[i];
            known[a]   = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      req_valid = 1'b1;
      req_addr  = 16'h0005;
      repeat (3) @(negedge clk);
      total++;
      if ({req_ready, wack, rvalid, done, err} !== 5'b10000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, wack, rvalid, done, err});
      end
      total++;
      if (rdata !== 16'h0000) begin
         bad++; $display("FAIL reset_rdata: got %h want 0000", rdata);
      end
      req_valid = 1'b0;
      proc_rst  = 1'b1;
   endtask

   task automatic test_single;
      int t;
      wd[0] = 16'hBEEF;
      run_txn(1'b1, 16'h0005, 3'd0, 1'b0, -1);
      t = t_acc;
      model_apply(1'b1, 16'h0005, 3'd0);
      total++;
      if (n_wack !== 1 || first_wack !== t + LAT) begin
         bad++; $display("FAIL single_wack: count %0d at %0d want 1 at %0d", n_wack, first_wack, t + LAT);
      end
      total++;
      if (done_cyc !== t + LAT + 1 || ready_cyc !== t + LAT + 2) begin
         bad++; $display("FAIL single_wr_done: done %0d ready %0d want %0d %0d",
                         done_cyc, ready_cyc, t + LAT + 1, t + LAT + 2);
      end
      run_txn(1'b0, 16'h0005, 3'd0, 1'b0, -1);
      t = t_acc;
      total++;
      if (n_rv !== 1 || first_rv !== t + LAT + 1 || rd_q.size() != 1 || rd_q[0] !== 16'hBEEF) begin
         bad++; $display("FAIL single_read: rv %0d at %0d data %h want 1 at %0d data beef",
                         n_rv, first_rv, (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx, t + LAT + 1);
      end
      total++;
      if (done_cyc !== t + LAT + 1 || ready_cyc !== t + LAT + 2 || n_wack !== 0) begin
         bad++; $display("FAIL single_rd_done: done %0d ready %0d wack %0d want %0d %0d 0",
                         done_cyc, ready_cyc, n_wack, t + LAT + 1, t + LAT + 2);
      end
   endtask

   task automatic test_burst;
      int t;
      for (int i = 0; i < 8; i++) wd[i] = 16'(i + 1);
      run_txn(1'b1, 16'h0010, 3'd7, 1'b0, -1);
      t = t_acc;
      model_apply(1'b1, 16'h0010, 3'd7);
      total++;
      if (n_wack !== 8 || first_wack !== t + LAT || last_wack !== t + LAT + 7) begin
         bad++; $display("FAIL burst_wack: count %0d span %0d..%0d want 8 span %0d..%0d",
                         n_wack, first_wack, last_wack, t + LAT, t + LAT + 7);
      end
      total++;
      if (n_done !== 1 || done_cyc !== t + LAT + 8 || ready_cyc !== t + LAT + 9) begin
         bad++; $display("FAIL burst_wr_done: n %0d done %0d ready %0d want 1 %0d %0d",
                         n_done, done_cyc, ready_cyc, t + LAT + 8, t + LAT + 9);
      end
      run_txn(1'b0, 16'h0010, 3'd7, 1'b0, -1);
      t = t_acc;
      total++;
      if (n_rv !== 8 || first_rv !== t + LAT + 1 || last_rv !== t + LAT + 8) begin
         bad++; $display("FAIL burst_rvalid: count %0d span %0d..%0d want 8 span %0d..%0d",
                         n_rv, first_rv, last_rv, t + LAT + 1, t + LAT + 8);
      end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i] !== 16'(i + 1)) begin
            bad++; $display("FAIL burst_data[%0d]: got %h want %h", i, rd_q[i], 16'(i + 1));
         end
      end
      total++;
      if (n_done !== 1 || done_cyc !== last_rv) begin
         bad++; $display("FAIL burst_rd_done: n %0d at %0d want 1 at %0d", n_done, done_cyc, last_rv);
      end
   endtask

   task automatic test_wrap;
      int t;
      for (int i = 0; i < 8; i++) wd[i] = 16'($urandom);
      run_txn(1'b1, 16'h00FE, 3'd3, 1'b0, -1);
      model_apply(1'b1, 16'h00FE, 3'd3);
      run_txn(1'b0, 16'h00FE, 3'd3, 1'b0, -1);
      t = t_acc;
      total++;
      if (n_rv !== 4 || first_rv !== t + LAT + 1) begin
         bad++; $display("FAIL wrap_rvalid: count %0d at %0d want 4 at %0d", n_rv, first_rv, t + LAT + 1);
      end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i] !== wd[i]) begin
            bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, rd_q[i], wd[i]);
         end
      end
   endtask

   task automatic test_out_of_range;
      int t;
      wd[0] = 16'h1234;
      run_txn(1'b1, 16'h0000, 3'd0, 1'b0, -1);
      model_apply(1'b1, 16'h0000, 3'd0);
      for (int i = 0; i < 8; i++) wd[i] = 16'hDEAD;
      run_txn(1'b1, 16'h0100, 3'd2, 1'b0, -1);
      t = t_acc;
      total++;
      if (n_done !== 1 || done_cyc !== t + 1 || err_obs !== 1'b1) begin
         bad++; $display("FAIL oor_done_err: n %0d at %0d err %b want 1 at %0d err 1",
                         n_done, done_cyc, err_obs, t + 1);
      end
      total++;
      if (n_wack !== 0 || ready_cyc !== t + 2) begin
         bad++; $display("FAIL oor_wack_ready: wack %0d ready %0d want 0 %0d", n_wack, ready_cyc, t + 2);
      end
      run_txn(1'b0, 16'h0000, 3'd0, 1'b0, -1);
      total++;
      if (rd_q.size() != 1 || rd_q[0] !== 16'h1234 || err_obs !== 1'b0) begin
         bad++; $display("FAIL oor_mem0: got %h err %b want 1234 err 0",
                         (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx, err_obs);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 8; i++) wd[i] = 16'hA000 + 16'(i);
      run_txn(1'b1, 16'h0040, 3'd7, 1'b0, -1);
      model_apply(1'b1, 16'h0040, 3'd7);
      for (int i = 0; i < 8; i++) wd[i] = {4'h5, 12'($urandom)};
      run_txn(1'b1, 16'h0040, 3'd7, 1'b0, LAT + 3);
      total++;
      if (rst_snap !== 5'b10000 || rst_rdata !== 16'h0000) begin
         bad++; $display("FAIL midrst_outputs: got %b rdata %h want 10000 rdata 0000", rst_snap, rst_rdata);
      end
      total++;
      if (n_wack !== 3 || n_done !== 0) begin
         bad++; $display("FAIL midrst_progress: wack %0d done %0d want 3 0", n_wack, n_done);
      end
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      proc_rst = 1'b1;
      for (int i = 0; i < 3; i++) ref_mem[8'h40 + 8'(i)] = wd[i];
      run_txn(1'b0, 16'h0040, 3'd7, 1'b0, -1);
      total++;
      if (rd_q.size() != 8) begin
         bad++; $display("FAIL midrst_readback_len: got %0d want 8", rd_q.size());
      end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i] !== ref_mem[8'h40 + 8'(i)]) begin
            bad++; $display("FAIL midrst_data[%0d]: got %h want %h", i, rd_q[i], ref_mem[8'h40 + 8'(i)]);
         end
      end
   endtask

   task automatic test_busy;
      int t, prev;
      nx_we = 1'b0; nx_addr = 16'h0012; nx_len = 3'd3;
      run_txn(1'b0, 16'h0010, 3'd7, 1'b1, -1);
      t = t_acc;
      total++;
      if (ready_cyc !== t + LAT + 9 || n_rv !== 8) begin
         bad++; $display("FAIL busy_first: ready %0d beats %0d want %0d 8", ready_cyc, n_rv, t + LAT + 9);
      end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i] !== ref_mem[8'h10 + 8'(i)]) begin
            bad++; $display("FAIL busy_first_data[%0d]: got %h want %h", i, rd_q[i], ref_mem[8'h10 + 8'(i)]);
         end
      end
      prev = ready_cyc;
      run_txn(nx_we, nx_addr, nx_len, 1'b0, -1);
      t = t_acc;
      total++;
      if (t !== prev || first_rv !== t + LAT + 1 || n_rv !== 4) begin
         bad++; $display("FAIL busy_second: acc %0d rv %0d n %0d want %0d %0d 4",
                         t, first_rv, n_rv, prev, prev + LAT + 1);
      end
      for (int i = 0; i < rd_q.size(); i++) begin
         total++;
         if (rd_q[i] !== ref_mem[8'h12 + 8'(i)]) begin
            bad++; $display("FAIL busy_second_data[%0d]: got %h want %h", i, rd_q[i], ref_mem[8'h12 + 8'(i)]);
         end
      end
   endtask

   task automatic test_random;
      logic       we;
      logic [15:0] addr;
      logic [2:0] len;
      logic [7:0] a;
      bit         oor;
      int         t, exp_ready;
      addr = '0;
      for (int it = 0; it < 10; it++) begin
         for (int j = 0; j < 2; j++) begin
            we  = (j == 0);
            len = 3'($urandom);
            if (j == 0) begin
               addr = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(256, 65535))
                                                  : 16'($urandom_range(0, 255));
            end
            oor = addr > 16'h00FF;
            for (int i = 0; i < 8; i++) wd[i] = 16'($urandom);
            run_txn(we, addr, len, 1'b0, -1);
            t = t_acc;
            if (oor) begin
               total++;
               if (done_cyc !== t + 1 || err_obs !== 1'b1 || n_wack !== 0 || n_rv !== 0) begin
                  bad++; $display("FAIL rand_oor: done %0d err %b wack %0d rv %0d want %0d 1 0 0",
                                  done_cyc, err_obs, n_wack, n_rv, t + 1);
               end
               exp_ready = t + 2;
            end else begin
               total++;
               if (done_cyc !== t + LAT + int'(len) + 1 || err_obs !== 1'b0 || n_done !== 1) begin
                  bad++; $display("FAIL rand_done: at %0d err %b n %0d want %0d 0 1",
                                  done_cyc, err_obs, n_done, t + LAT + int'(len) + 1);
               end
               if (we) begin
                  total++;
                  if (n_wack !== int'(len) + 1 || first_wack !== t + LAT || n_rv !== 0) begin
                     bad++; $display("FAIL rand_wack: count %0d at %0d rv %0d want %0d at %0d rv 0",
                                     n_wack, first_wack, n_rv, int'(len) + 1, t + LAT);
                  end
               end else begin
                  total++;
                  if (n_rv !== int'(len) + 1 || first_rv !== t + LAT + 1 || n_wack !== 0) begin
                     bad++; $display("FAIL rand_rvalid: count %0d at %0d wack %0d want %0d at %0d wack 0",
                                     n_rv, first_rv, n_wack, int'(len) + 1, t + LAT + 1);
                  end
                  for (int i = 0; i < rd_q.size(); i++) begin
                     a = addr[7:0] + 8'(i);
                     if (known[a]) begin
                        total++;
                        if (rd_q[i] !== ref_mem[a]) begin
                           bad++; $display("FAIL rand_data[%h]: got %h want %h", a, rd_q[i], ref_mem[a]);
                        end
                     end
                  end
               end
               exp_ready = t + LAT + int'(len) + 2;
            end
            total++;
            if (ready_cyc !== exp_ready) begin
               bad++; $display("FAIL rand_ready: got %0d want %0d", ready_cyc, exp_ready);
            end
            model_apply(we, addr, len);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = '0;
         known[i]   = 1'b0;
      end
      for (int i = 0; i < 8; i++) wd[i] = '0;
      test_reset();
      test_single();
      test_burst();
      test_wrap();
      test_out_of_range();
      test_reset_mid();
      test_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
